// File: rtl/sram_like_bus_arbiter.sv
// Shares one SRAM-like memory port between the fetch master (inst_*) and the
// load/store master (data_*). The data master wins on a fresh grant. A grant stays
// locked to its master until the slave accepts. Responses come back in request
// order, and a small owner FIFO routes each one to the master that issued it.
module sram_like_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // fetch master
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  // load/store master
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [3:0]            data_wstrb,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_WIDTH-1:0] data_rdata,
  // memory slave
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [3:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  protocol_error
);

  localparam int unsigned PtrW = $clog2(OUTSTANDING_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLockData, StLockInst} state_e;
  typedef enum logic [1:0] {GntNone, GntData, GntInst} grant_e;

  state_e                       state_q, state_d;
  grant_e                       grant;
  logic [OUTSTANDING_DEPTH-1:0] owner_q;  // 1 = data master, 0 = fetch master
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]              count_q;
  logic                         err_q;

  logic full, empty, accept, push, pop, err_set, head_is_data;

  assign full  = (count_q == CntW'(OUTSTANDING_DEPTH));
  assign empty = (count_q == '0);

  // Pick the master driving the bus this cycle; a lock ignores the other master and
  // the full condition, while a fresh grant is blocked when the FIFO is full.
  always_comb begin
    grant = GntNone;
    unique case (state_q)
      StIdle: begin
        if (!full) begin
          if (data_req) begin
            grant = GntData;
          end else if (inst_req) begin
            grant = GntInst;
          end
        end
      end
      StLockData: if (data_req) grant = GntData;
      StLockInst: if (inst_req) grant = GntInst;
      default:    grant = GntNone;
    endcase
    // Everything facing the slave and the masters is quiet while reset is held.
    if (!reset) grant = GntNone;
  end

  // Mux the granted master's request fields onto the bus.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (grant)
      GntData: begin
        bus_req   = 1'b1;
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end
      GntInst: begin
        bus_req   = 1'b1;
        bus_size  = 2'd2;
        bus_addr  = inst_addr;
      end
      default: ;
    endcase
  end

  assign accept       = bus_req & bus_addr_ok;
  assign data_addr_ok = accept & (grant == GntData);
  assign inst_addr_ok = accept & (grant == GntInst);

  // An accept while full has no slot to record its owner; it is dropped and flagged.
  assign push    = accept & ~full;
  assign pop     = reset & bus_data_ok & ~empty;
  assign err_set = reset & ((bus_data_ok & empty) | (accept & full));

  assign head_is_data = owner_q[rd_ptr_q];

  // Route each response to the owner at the FIFO head; the idle side reads zero.
  always_comb begin
    data_data_ok = pop & head_is_data;
    inst_data_ok = pop & ~head_is_data;
    data_rdata   = data_data_ok ? bus_rdata : '0;
    inst_rdata   = inst_data_ok ? bus_rdata : '0;
  end

  assign protocol_error = err_q;

  // Lock onto a master whose request was not accepted; release on accept or req drop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant == GntData && !bus_addr_ok) begin
          state_d = StLockData;
        end else if (grant == GntInst && !bus_addr_ok) begin
          state_d = StLockInst;
        end
      end
      StLockData: if (!data_req || bus_addr_ok) state_d = StIdle;
      StLockInst: if (!inst_req || bus_addr_ok) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM, owner FIFO and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        owner_q[wr_ptr_q] <= (grant == GntData);
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// Bench for sram_like_bus_arbiter: directed scenarios followed by random master/slave
// traffic, every cycle compared against a queue-based reference model.
module tb_sram_like_bus_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          bus_req, bus_wr, bus_addr_ok, bus_data_ok, protocol_error;
  logic [1:0]    bus_size;
  logic [3:0]    bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clock = ~clock;

  sram_like_bus_arbiter #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .OUTSTANDING_DEPTH(DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_wstrb    (data_wstrb),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .bus_req       (bus_req),
    .bus_wr        (bus_wr),
    .bus_size      (bus_size),
    .bus_wstrb     (bus_wstrb),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_addr_ok   (bus_addr_ok),
    .bus_data_ok   (bus_data_ok),
    .bus_rdata     (bus_rdata),
    .protocol_error(protocol_error)
  );

  // Reference model: owner of each outstanding request in order (1 = data),
  // the master currently holding a lock (-1 none, 0 inst, 1 data), sticky error.
  bit m_q[$];
  int m_lock;
  bit m_err;
  bit acc_inst, acc_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which master the spec's rules say owns the bus right now (-1 none).
  function automatic int exp_grant();
    if (!reset) return -1;
    if (m_lock == 1) return data_req ? 1 : -1;
    if (m_lock == 0) return inst_req ? 0 : -1;
    if (m_q.size() == DEPTH) return -1;
    if (data_req) return 1;
    if (inst_req) return 0;
    return -1;
  endfunction

  task automatic check_outputs(input string ph);
    int g;
    bit pop, hd;
    g   = exp_grant();
    pop = reset && bus_data_ok && (m_q.size() > 0);
    hd  = pop ? m_q[0] : 1'b0;
    check({ph, ".bus_req"}, bus_req, g != -1);
    check({ph, ".bus_wr"}, bus_wr, (g == 1) ? data_wr : 1'b0);
    check({ph, ".bus_size"}, bus_size, (g == 1) ? data_size : ((g == 0) ? 2'd2 : 2'd0));
    check({ph, ".bus_wstrb"}, bus_wstrb, (g == 1) ? data_wstrb : 4'd0);
    check({ph, ".bus_addr"}, bus_addr, (g == 1) ? data_addr : ((g == 0) ? inst_addr : '0));
    check({ph, ".bus_wdata"}, bus_wdata, (g == 1) ? data_wdata : '0);
    check({ph, ".inst_addr_ok"}, inst_addr_ok, (g == 0) && bus_addr_ok);
    check({ph, ".data_addr_ok"}, data_addr_ok, (g == 1) && bus_addr_ok);
    check({ph, ".inst_data_ok"}, inst_data_ok, pop && !hd);
    check({ph, ".data_data_ok"}, data_data_ok, pop && hd);
    check({ph, ".inst_rdata"}, inst_rdata, (pop && !hd) ? bus_rdata : '0);
    check({ph, ".data_rdata"}, data_rdata, (pop && hd) ? bus_rdata : '0);
    check({ph, ".protocol_error"}, protocol_error, m_err);
  endtask

  // One clock: check settled outputs, then advance the model across the edge.
  task automatic cycle(input string ph);
    int g;
    bit acc, pop, was_full, was_empty;
    #3;
    check_outputs(ph);
    g         = exp_grant();
    acc       = (g != -1) && bus_addr_ok;
    pop       = reset && bus_data_ok && (m_q.size() > 0);
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    @(posedge clock);
    acc_inst = acc && (g == 0);
    acc_data = acc && (g == 1);
    if (reset) begin
      if (pop) void'(m_q.pop_front());
      if (acc && !was_full) m_q.push_back(g == 1);
      if ((bus_data_ok && was_empty) || (acc && was_full)) m_err = 1'b1;
      if (m_lock == -1) begin
        if (g != -1 && !bus_addr_ok) m_lock = g;
      end else if (m_lock == 1) begin
        if (!data_req || bus_addr_ok) m_lock = -1;
      end else begin
        if (!inst_req || bus_addr_ok) m_lock = -1;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = -1;
    m_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'd0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic drain(input string ph);
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    for (int i = 0; i < 16 && m_q.size() > 0; i++) begin
      bus_data_ok = 1'b1;
      bus_rdata   = $urandom;
      cycle(ph);
    end
    bus_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    acc_inst = 1'b0;
    acc_data = 1'b0;

    // Outputs stay quiet during reset even with requests pending.
    data_req    = 1'b1;
    inst_req    = 1'b1;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    @(posedge clock);
    #1;
    cycle("rst");
    check("rst.bus_req_const", bus_req, 1'b0);
    idle_inputs();
    reset = 1'b1;
    cycle("rst_rel");

    // 1: simultaneous requests, data first, responses routed in order.
    data_req    = 1'b1; data_addr = 32'hD000_0010; data_size = 2'd2;
    inst_req    = 1'b1; inst_addr = 32'h1000_0000; bus_addr_ok = 1'b1;
    #3;
    check("t1.data_addr_ok", data_addr_ok, 1'b1);
    check("t1.inst_addr_ok", inst_addr_ok, 1'b0);
    cycle("t1a");
    data_req = 1'b0;
    #3;
    check("t1.inst_accept", inst_addr_ok, 1'b1);
    cycle("t1b");
    inst_req    = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_AAAA;
    #3;
    check("t1.resp_a_data", data_data_ok, 1'b1);
    cycle("t1c");
    bus_rdata = 32'hBBBB_BBBB;
    #3;
    check("t1.resp_b_inst", inst_data_ok, 1'b1);
    check("t1.resp_b_rdata", inst_rdata, 32'hBBBB_BBBB);
    cycle("t1d");
    bus_data_ok = 1'b0;

    // 2: fetch locked while slave stalls; data waits.
    inst_req = 1'b1; inst_addr = 32'h0000_0400; bus_addr_ok = 1'b0;
    cycle("t2_0");
    data_req = 1'b1; data_addr = 32'h0000_0800; data_wr = 1'b1; data_wstrb = 4'hF;
    data_wdata = 32'h1234_5678;
    for (int i = 1; i < 3; i++) begin
      #3;
      check("t2.locked_addr", bus_addr, 32'h0000_0400);
      cycle("t2_stall");
    end
    bus_addr_ok = 1'b1;
    #3;
    check("t2.inst_accept", inst_addr_ok, 1'b1);
    cycle("t2_acc");
    inst_req = 1'b0;
    #3;
    check("t2.data_next", bus_addr, 32'h0000_0800);
    cycle("t2_data");
    data_req = 1'b0; data_wr = 1'b0;
    drain("t2_drain");

    // 3: fill the FIFO, grants blocked until one response has popped.
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_addr = 32'h100 + 4 * i;
      cycle("t3_fill");
    end
    #3;
    check("t3.full_blocks", bus_req, 1'b0);
    cycle("t3_full");
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_0033;
    #3;
    check("t3.pop_cycle_blocked", bus_req, 1'b0);
    cycle("t3_pop");
    bus_data_ok = 1'b0;
    #3;
    check("t3.reopen", bus_req, 1'b1);
    cycle("t3_reopen");
    drain("t3_drain");

    // 4: hold two outstanding, then push+pop every cycle across pointer wraps.
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    cycle("t4_pre0");
    inst_req = 1'b0; data_req = 1'b1;
    cycle("t4_pre1");
    bus_data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_req  = (i % 3) != 0;
      inst_req  = !data_req;
      bus_rdata = 32'h4000 + i;
      cycle("t4_pp");
    end
    data_req = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b0;
    check("t4.count_two", m_q.size(), 2);
    drain("t4_drain");

    // 5: response with nothing outstanding.
    bus_data_ok = 1'b1;
    #3;
    check("t5.no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    cycle("t5_err");
    bus_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t5.sticky", protocol_error, 1'b1);
      cycle("t5_hold");
    end
    reset = 1'b0;
    model_reset();
    #1;
    check("t5.cleared", protocol_error, 1'b0);
    cycle("t5_rst");
    reset = 1'b1;

    // 6: reset in the middle of a locked data request with three outstanding.
    data_req = 1'b1; bus_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_addr = 32'h2000 + 4 * i;
      cycle("t6_fill");
    end
    bus_addr_ok = 1'b0; data_addr = 32'h3000;
    cycle("t6_lock");
    reset = 1'b0;
    model_reset();
    #1;
    check("t6.bus_req_async", bus_req, 1'b0);
    check("t6.addr_ok_async", data_addr_ok, 1'b0);
    cycle("t6_in_rst");
    reset = 1'b1; data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h5000; bus_addr_ok = 1'b1;
    #3;
    check("t6.idle_grant", inst_addr_ok, 1'b1);
    cycle("t6_after");
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    drain("t6_drain");

    // Random traffic: masters hold requests until accepted, slave answers in order.
    for (int n = 0; n < 600; n++) begin
      if (acc_inst || !inst_req) begin
        inst_req  = $urandom_range(0, 1);
        inst_addr = $urandom;
      end
      if (acc_data || !data_req) begin
        data_req   = $urandom_range(0, 1);
        data_wr    = $urandom_range(0, 1);
        data_size  = $urandom_range(0, 2);
        data_wstrb = $urandom;
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      bus_addr_ok = $urandom_range(0, 1);
      bus_data_ok = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      bus_rdata   = $urandom;
      cycle("rnd");
    end
    drain("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
